// File: rtl/retire_commit_pkg.sv
// rtl/retire_commit_pkg.sv - shared ROB head field layout, retire state encoding, RRAT packing widths
package retire_commit_pkg;

  localparam int COMPLETE_BIT  = 0;
  localparam int MISPRED_BIT   = 1;
  localparam int DEST_REQD_BIT = 2;
  localparam int ARCH_LSB      = 3;
  localparam int ARCH_W        = 5;
  localparam int PHYS_LSB      = 8;
  localparam int PC_W          = 32;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  function automatic int pc_lsb(int phys_w);
    return PHYS_LSB + phys_w;
  endfunction

  // Flat RAT image: entry i occupies bits [p*i +: p]; rename unpacks with the same width.
  function automatic int rrat_flat_w(int phys_w, int arch_regs);
    return phys_w * arch_regs;
  endfunction

endpackage

// File: rtl/retire_commit_if.sv
// rtl/retire_commit_if.sv - ROB / freelist / rename / fetch signals around the retire stage
interface retire_commit_if
  import retire_commit_pkg::*;
#(
  parameter int PHYSREGS_DEPTH = 6,
  parameter int ARCHREGS_DEPTH = 32,
  parameter int ROBHEAD_WIDTH  = 40 + PHYSREGS_DEPTH
);
  logic                                               fROB_empty_IN;
  logic [ROBHEAD_WIDTH-1:0]                           fROB_headData_IN;
  logic                                               tROB_popReq_OUT;
  logic                                               fFreeL_full_IN;
  logic                                               tFreeL_pushReq_OUT;
  logic [PHYSREGS_DEPTH-1:0]                          tFreeL_pushData_OUT;
  logic                                               tRenRatOverwrite_OUT;
  logic [rrat_flat_w(PHYSREGS_DEPTH, ARCHREGS_DEPTH)-1:0] tRenRatOverwriteData_OUT;
  logic                                               tFlush_OUT;
  logic                                               tFreeze_OUT;
  logic                                               tRedirectValid_OUT;
  logic [PC_W-1:0]                                    tRedirectPC_OUT;
  logic [31:0]                                        tRetireCount_OUT;

  modport master (
    input  fROB_empty_IN, fROB_headData_IN, fFreeL_full_IN,
    output tROB_popReq_OUT, tFreeL_pushReq_OUT, tFreeL_pushData_OUT,
           tRenRatOverwrite_OUT, tRenRatOverwriteData_OUT, tFlush_OUT,
           tFreeze_OUT, tRedirectValid_OUT, tRedirectPC_OUT, tRetireCount_OUT
  );

  modport slave (
    output fROB_empty_IN, fROB_headData_IN, fFreeL_full_IN,
    input  tROB_popReq_OUT, tFreeL_pushReq_OUT, tFreeL_pushData_OUT,
           tRenRatOverwrite_OUT, tRenRatOverwriteData_OUT, tFlush_OUT,
           tFreeze_OUT, tRedirectValid_OUT, tRedirectPC_OUT, tRetireCount_OUT
  );
endinterface

// File: rtl/retire_commit_rrat_file.sv
// rtl/retire_commit_rrat_file.sv - retirement RAT storage, one write port, one read port, flat image
module rrat_file
  import retire_commit_pkg::*;
#(
  parameter int P = 6,
  parameter int N = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              we,
  input  logic [ARCH_W-1:0] waddr,
  input  logic [P-1:0]      wdata,
  input  logic [ARCH_W-1:0] raddr,
  output logic [P-1:0]      rdata,
  output logic [P*N-1:0]    flat
);
  logic [P-1:0] regs [N];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < N; i++) regs[i] <= P'(i);
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  // Read sees the pre-write value when the same entry is written this cycle.
  assign rdata = regs[raddr];

  for (genvar g = 0; g < N; g++) begin : g_flat
    assign flat[g*P +: P] = regs[g];
  end
endmodule

// File: rtl/retire_commit.sv
// rtl/retire_commit.sv - in-order retirement: RRAT update, freelist return, mispredict drain and recovery
module retire_commit
  import retire_commit_pkg::*;
#(
  parameter int PHYSREGS_DEPTH = 6,
  parameter int ARCHREGS_DEPTH = 32,
  parameter int ROBHEAD_WIDTH  = 40 + PHYSREGS_DEPTH
) (
  input  logic             CLK,
  input  logic             RESET,
  retire_commit_if.master  bus
);
  localparam int P = PHYSREGS_DEPTH;

  state_t              state;
  logic                pop;
  logic                rrat_we;
  logic [P-1:0]        rrat_old;
  logic [P*ARCHREGS_DEPTH-1:0] rrat_flat;
  logic [PC_W-1:0]     pc_q;
  logic                recover_q;
  logic                freeze_q;
  logic                push_q;
  logic [P-1:0]        push_data_q;
  logic [31:0]         count_q;

  logic                head_complete, head_mispred, head_dest;
  logic [ARCH_W-1:0]   head_arch;
  logic [P-1:0]        head_phys;
  logic [PC_W-1:0]     head_pc;

  assign head_complete = bus.fROB_headData_IN[COMPLETE_BIT];
  assign head_mispred  = bus.fROB_headData_IN[MISPRED_BIT];
  assign head_dest     = bus.fROB_headData_IN[DEST_REQD_BIT];
  assign head_arch     = bus.fROB_headData_IN[ARCH_LSB +: ARCH_W];
  assign head_phys     = bus.fROB_headData_IN[PHYS_LSB +: P];
  assign head_pc       = bus.fROB_headData_IN[pc_lsb(P) +: PC_W];

  always_comb begin
    pop = 1'b0;
    case (state)
      ST_RUN:   pop = !bus.fROB_empty_IN && head_complete && !bus.fFreeL_full_IN;
      ST_DRAIN: pop = !bus.fROB_empty_IN && !bus.fFreeL_full_IN;
      default:  pop = 1'b0;
    endcase
    if (!RESET) pop = 1'b0;
  end

  assign rrat_we = (state == ST_RUN) && pop && head_dest && (head_arch != '0);

  rrat_file #(.P(P), .N(ARCHREGS_DEPTH)) u_rrat (
    .clk    (CLK),
    .resetn (RESET),
    .we     (rrat_we),
    .waddr  (head_arch),
    .wdata  (head_phys),
    .raddr  (head_arch),
    .rdata  (rrat_old),
    .flat   (rrat_flat)
  );

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state       <= ST_RUN;
      pc_q        <= '0;
      recover_q   <= 1'b0;
      freeze_q    <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      count_q     <= '0;
    end else begin
      push_q    <= pop && head_dest;
      recover_q <= 1'b0;
      // Committed writes free the previous mapping; arch 0 and squashed entries free their own tag.
      if (pop && head_dest)
        push_data_q <= rrat_we ? rrat_old : head_phys;
      else
        push_data_q <= '0;
      case (state)
        ST_RUN: begin
          if (pop) begin
            count_q <= count_q + 32'd1;
            if (head_mispred) begin
              pc_q     <= head_pc;
              state    <= ST_DRAIN;
              freeze_q <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (bus.fROB_empty_IN) begin
            state     <= ST_RECOVER;
            freeze_q  <= 1'b0;
            recover_q <= 1'b1;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  assign bus.tROB_popReq_OUT          = pop;
  assign bus.tFreeL_pushReq_OUT       = push_q;
  assign bus.tFreeL_pushData_OUT      = push_data_q;
  assign bus.tRenRatOverwrite_OUT     = recover_q;
  assign bus.tRenRatOverwriteData_OUT = recover_q ? rrat_flat : '0;
  assign bus.tFlush_OUT               = recover_q;
  assign bus.tFreeze_OUT              = freeze_q;
  assign bus.tRedirectValid_OUT       = recover_q;
  assign bus.tRedirectPC_OUT          = recover_q ? pc_q : '0;
  assign bus.tRetireCount_OUT         = count_q;
endmodule

// File: tb/tb_retire_commit.sv
// tb/tb_retire_commit.sv - vector table, directed recovery sequences and random ROB traffic against a reference model
module tb_retire_commit;
  localparam int P = 6;
  localparam int N = 32;
  localparam int W = 40 + P;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  retire_commit_if #(.PHYSREGS_DEPTH(P), .ARCHREGS_DEPTH(N), .ROBHEAD_WIDTH(W)) bus ();

  retire_commit #(.PHYSREGS_DEPTH(P), .ARCHREGS_DEPTH(N), .ROBHEAD_WIDTH(W)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int          m_rrat [N];
  logic [31:0] m_cnt;
  int          m_mode;   // 0 committing, 1 squashing, 2 restoring
  bit          m_pend;
  int          m_pval;
  logic [31:0] m_pc;
  bit          e_pop;
  bit          s_pop;

  typedef struct {
    bit empty; bit comp; bit dest; int arch; int phys; bit full;
    bit exp_pop; bit exp_push; int exp_data; int exp_cnt;
  } vec_t;
  vec_t tbl [10];

  logic [W-1:0] robq [$];

  task automatic chk(string nm, logic [N*P-1:0] act, logic [N*P-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(bit c, bit mp, bit d, int a, int p, logic [31:0] pc);
    logic [W-1:0] h;
    h = '0;
    h[0] = c; h[1] = mp; h[2] = d;
    h[7:3] = a[4:0];
    h[8 +: P] = p[P-1:0];
    h[8+P +: 32] = pc;
    return h;
  endfunction

  task automatic drive(bit e, bit c, bit mp, bit d, int a, int p, logic [31:0] pc, bit f);
    bus.fROB_empty_IN    = e;
    bus.fROB_headData_IN = mk(c, mp, d, a, p, pc);
    bus.fFreeL_full_IN   = f;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_rrat[i] = i;
    m_cnt = 0; m_mode = 0; m_pend = 0; m_pval = 0; m_pc = 0;
  endtask

  function automatic int ovr_field(int i);
    logic [N*P-1:0] v;
    v = bus.tRenRatOverwriteData_OUT;
    return int'(v[i*P +: P]);
  endfunction

  task automatic cycle();
    logic [W-1:0] h;
    logic [N*P-1:0] pk;
    bit c, mp, d;
    int a, p;
    @(negedge clk);
    h = bus.fROB_headData_IN;
    c = h[0]; mp = h[1]; d = h[2];
    a = int'(h[7:3]); p = int'(h[8 +: P]);
    if (!rst || bus.fROB_empty_IN || bus.fFreeL_full_IN) e_pop = 0;
    else if (m_mode == 0) e_pop = c;
    else e_pop = (m_mode == 1);
    s_pop = bus.tROB_popReq_OUT;
    chk("pop", s_pop, e_pop);
    chk("push_req", bus.tFreeL_pushReq_OUT, m_pend);
    if (m_pend) chk("push_data", bus.tFreeL_pushData_OUT, m_pval);
    chk("retire_count", bus.tRetireCount_OUT, m_cnt);
    chk("freeze", bus.tFreeze_OUT, m_mode == 1);
    chk("flush", bus.tFlush_OUT, m_mode == 2);
    chk("rat_overwrite", bus.tRenRatOverwrite_OUT, m_mode == 2);
    chk("redirect_valid", bus.tRedirectValid_OUT, m_mode == 2);
    if (m_mode == 2) begin
      for (int i = 0; i < N; i++) pk[i*P +: P] = m_rrat[i][P-1:0];
      chk("overwrite_data", bus.tRenRatOverwriteData_OUT, pk);
      chk("redirect_pc", bus.tRedirectPC_OUT, m_pc);
    end
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      m_pend = e_pop && d;
      m_pval = (m_mode == 0 && a != 0) ? m_rrat[a] : p;
      case (m_mode)
        0: if (e_pop) begin
             if (d && a != 0) m_rrat[a] = p;
             m_cnt = m_cnt + 1;
             if (mp) begin m_pc = h[8+P +: 32]; m_mode = 1; end
           end
        1: if (bus.fROB_empty_IN) m_mode = 2;
        default: m_mode = 0;
      endcase
    end
    #1;
  endtask

  initial begin
    rst = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(posedge clk); #1;
    cycle();
    chk("reset_count", bus.tRetireCount_OUT, 0);
    chk("reset_push", bus.tFreeL_pushReq_OUT, 0);
    rst = 1'b1;

    tbl[0] = '{1, 0, 0, 0,  0, 0, 0, 0,  0, 0};
    tbl[1] = '{0, 0, 1, 5, 40, 0, 0, 0,  0, 0};
    tbl[2] = '{0, 1, 1, 5, 40, 1, 0, 0,  0, 0};
    tbl[3] = '{0, 1, 1, 5, 40, 0, 1, 1,  5, 1};
    tbl[4] = '{0, 1, 1, 5, 41, 0, 1, 1, 40, 2};
    tbl[5] = '{0, 1, 0, 7,  9, 0, 1, 0,  0, 3};
    tbl[6] = '{0, 1, 1, 0, 50, 0, 1, 1, 50, 4};
    tbl[7] = '{0, 1, 1, 0, 51, 0, 1, 1, 51, 5};
    tbl[8] = '{0, 1, 1, 7, 12, 0, 1, 1,  7, 6};
    tbl[9] = '{1, 0, 0, 0,  0, 0, 0, 0,  0, 6};
    for (int k = 0; k < 10; k++) begin
      drive(tbl[k].empty, tbl[k].comp, 0, tbl[k].dest, tbl[k].arch, tbl[k].phys, 0, tbl[k].full);
      cycle();
      chk("tbl_pop", s_pop, tbl[k].exp_pop);
      chk("tbl_push", bus.tFreeL_pushReq_OUT, tbl[k].exp_push);
      if (tbl[k].exp_push) chk("tbl_push_data", bus.tFreeL_pushData_OUT, tbl[k].exp_data);
      chk("tbl_count", bus.tRetireCount_OUT, tbl[k].exp_cnt);
    end

    // Incomplete head stalls for three cycles.
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 1, 9, 20, 0, 0);
      cycle();
      chk("stall_pop", s_pop, 0);
    end
    drive(0, 1, 0, 1, 9, 20, 0, 0);
    cycle();
    chk("stall_release_pop", s_pop, 1);
    chk("stall_push_data", bus.tFreeL_pushData_OUT, 9);

    // Freelist full blocks the pop but not the push already issued.
    for (int k = 0; k < 2; k++) begin
      drive(0, 1, 0, 1, 10, 21, 0, 1);
      cycle();
      chk("full_pop", s_pop, 0);
    end
    drive(0, 1, 0, 1, 10, 21, 0, 0);
    cycle();
    chk("full_release_pop", s_pop, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    chk("full_push", bus.tFreeL_pushReq_OUT, 1);
    chk("full_push_data", bus.tFreeL_pushData_OUT, 10);
    cycle();

    // Mispredict, two squashed entries, then restore.
    drive(0, 1, 1, 1, 3, 33, 32'h0040_0100, 0);
    cycle();
    chk("mp_pop", s_pop, 1);
    chk("mp_push3", bus.tFreeL_pushData_OUT, 3);
    chk("mp_freeze", bus.tFreeze_OUT, 1);
    drive(0, 0, 0, 1, 0, 34, 0, 0);
    cycle();
    chk("drain_push34", bus.tFreeL_pushData_OUT, 34);
    drive(0, 0, 0, 1, 0, 35, 0, 0);
    cycle();
    chk("drain_push35", bus.tFreeL_pushData_OUT, 35);
    chk("drain_freeze", bus.tFreeze_OUT, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    chk("rec_flush", bus.tFlush_OUT, 1);
    chk("rec_freeze", bus.tFreeze_OUT, 0);
    chk("rec_rrat3", ovr_field(3), 33);
    chk("rec_rrat5", ovr_field(5), 41);
    chk("rec_rrat0", ovr_field(0), 0);
    chk("rec_pc", bus.tRedirectPC_OUT, 32'h0040_0100);
    cycle();
    chk("rec_one_cycle", bus.tFlush_OUT, 0);

    // Reset in the middle of a drain.
    drive(0, 1, 1, 1, 4, 44, 32'h0000_1234, 0);
    cycle();
    drive(0, 1, 0, 1, 6, 45, 0, 0);
    cycle();
    rst = 1'b0;
    cycle();
    chk("rst_drain_freeze", bus.tFreeze_OUT, 0);
    chk("rst_drain_count", bus.tRetireCount_OUT, 0);
    rst = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    chk("rst_no_recover", bus.tFlush_OUT, 0);
    drive(0, 1, 1, 1, 4, 44, 32'h0000_2000, 0);
    cycle();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    chk("post_rst_flush", bus.tFlush_OUT, 1);
    chk("post_rst_rrat4", ovr_field(4), 44);
    chk("post_rst_rrat10", ovr_field(10), 10);
    chk("post_rst_pc", bus.tRedirectPC_OUT, 32'h0000_2000);
    cycle();

    // Random ROB traffic.
    for (int k = 0; k < 3000; k++) begin
      logic [W-1:0] h;
      if (m_mode == 0 && robq.size() < 4 && ($urandom % 2) == 1)
        robq.push_back(mk(0, ($urandom % 12) == 0, ($urandom % 4) != 0,
                          int'($urandom % 32), int'($urandom % 64), $urandom));
      h = (robq.size() > 0) ? robq[0] : '0;
      h[0] = ($urandom % 3) != 0;
      bus.fROB_empty_IN    = (robq.size() == 0);
      bus.fROB_headData_IN = h;
      bus.fFreeL_full_IN   = ($urandom % 5) == 0;
      rst = ($urandom % 500) != 0;
      cycle();
      if (e_pop) void'(robq.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
